// File: rtl/hedios_pkg.sv
// Hedios controller shared definitions: client/response command codes,
// error codes and the controller state encoding.
package hedios_pkg;

  // client -> endpoint commands
  localparam logic [7:0] CMD_PING             = 8'h01;
  localparam logic [7:0] CMD_UPDATE_SLOT      = 8'h02;
  localparam logic [7:0] CMD_UPDATE_ALL       = 8'h03;
  localparam logic [7:0] CMD_ASK_SLOT_COUNT   = 8'h04;
  localparam logic [7:0] CMD_ASK_ACTION_COUNT = 8'h05;
  localparam logic [7:0] CMD_UPDATE_RANGE     = 8'h06;
  localparam logic [7:0] CMD_RESET            = 8'h55;

  // endpoint -> client responses
  localparam logic [7:0] RSP_DONE           = 8'h02;
  localparam logic [7:0] RSP_PONG           = 8'h03;
  localparam logic [7:0] RSP_SLOT_COUNT     = 8'h05;
  localparam logic [7:0] RSP_ACTION_COUNT   = 8'h06;
  localparam logic [7:0] RSP_ERROR          = 8'h08;
  localparam logic [7:0] RSP_INVALID_SLOT   = 8'h09;
  localparam logic [7:0] RSP_INVALID_ACTION = 8'h0A;
  localparam logic [7:0] RSP_UNKNOWN        = 8'h0B;
  localparam logic [7:0] RSP_SLOT_BASE      = 8'h80;

  // payload of an ERROR response
  localparam int ERR_LOST_DATA = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_DECODE,
    ST_TX_WAIT,
    ST_STREAM,
    ST_STREAM_GAP,
    ST_VAR_PULSE
  } state_t;

endpackage

// File: rtl/hedios_controller_v2_if.sv
// Packet FIFO bundle between the Hedios controller and the serial rx/tx FIFOs.
//   rx_empty, rx_lost_data, rx_command, rx_data : rx FIFO status and head packet
//   rx_pop_packet                               : pop strobe to the rx FIFO
//   tx_full                                     : tx FIFO full
//   tx_command, tx_data, tx_push_packet         : response packet and push strobe
// master = controller side, slave = FIFO side.
interface hedios_controller_v2_if #(parameter int DATA_W = 32);
  logic              rx_empty;
  logic              rx_lost_data;
  logic [7:0]        rx_command;
  logic [DATA_W-1:0] rx_data;
  logic              rx_pop_packet;
  logic              tx_full;
  logic [7:0]        tx_command;
  logic [DATA_W-1:0] tx_data;
  logic              tx_push_packet;

  modport master (
    input  rx_empty, rx_lost_data, rx_command, rx_data, tx_full,
    output rx_pop_packet, tx_command, tx_data, tx_push_packet
  );

  modport slave (
    output rx_empty, rx_lost_data, rx_command, rx_data, tx_full,
    input  rx_pop_packet, tx_command, tx_data, tx_push_packet
  );
endinterface

// File: rtl/hedios_controller_v2.sv
// Hedios command controller: pops client packets, decodes them, reads slots,
// fires action pulses and pushes response packets, honouring tx backpressure.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   bus (master)          : rx/tx packet FIFO bundle
//   rst_device            : one-cycle device reset request
//   slots                 : flat slot vector, slot i at [i*DATA_W +: DATA_W]
//   var_actions           : one-cycle pulses of parameterised actions
//   var_action_parameter  : latched action parameters, same flat layout
//   varless_actions       : one-cycle pulses of parameterless actions
//
// state         | meaning
// --------------|-------------------------------------------------------
// ST_IDLE       | report pending rx loss, else pop next packet
// ST_POP        | pop strobe out, head packet appears next cycle
// ST_DECODE     | decode head packet, load response or start action/stream
// ST_TX_WAIT    | hold loaded response until tx has room, then push it
// ST_STREAM     | push next slot of a range, or load DONE when finished
// ST_STREAM_GAP | spacer so stream pushes are never back-to-back
// ST_VAR_PULSE  | parameter already visible; pulse the var action
module hedios_controller_v2
  import hedios_pkg::*;
#(
  parameter int DATA_W               = 32,
  parameter int SLOT_COUNT           = 4,
  parameter int VAR_ACTION_COUNT     = 2,
  parameter int VARLESS_ACTION_COUNT = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  hedios_controller_v2_if.master             bus,
  output logic                               rst_device,
  input  logic [SLOT_COUNT*DATA_W-1:0]       slots,
  output logic [VAR_ACTION_COUNT-1:0]        var_actions,
  output logic [VAR_ACTION_COUNT*DATA_W-1:0] var_action_parameter,
  output logic [VARLESS_ACTION_COUNT-1:0]    varless_actions
);

  localparam logic [7:0] SLOT_COUNT_B = 8'(SLOT_COUNT);
  localparam logic [7:0] VAR_COUNT_B  = 8'(VAR_ACTION_COUNT);
  localparam logic [7:0] VL_COUNT_B   = 8'(VARLESS_ACTION_COUNT);

  state_t state_q, state_d;
  logic pop_q, pop_d, push_q, push_d, rst_dev_q, rst_dev_d;
  logic [7:0] tx_cmd_q, tx_cmd_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [VAR_ACTION_COUNT-1:0] var_q, var_d;
  logic [VARLESS_ACTION_COUNT-1:0] vl_q, vl_d;
  logic [VAR_ACTION_COUNT*DATA_W-1:0] param_q;
  logic [7:0] cur_q, cur_d, end_q, end_d, cnt_q, cnt_d;
  logic [5:0] act_idx_q, act_idx_d;
  logic param_we, lost_q, lost_clr;

  logic [7:0] cmd;
  logic [15:0] rx_lo;
  logic [7:0] sel_idx;
  logic [DATA_W-1:0] slot_sel;
  logic [7:0] rng_start, rng_count;
  logic [8:0] rng_end;

  assign cmd   = bus.rx_command;
  assign rx_lo = 16'(bus.rx_data);   // zero-extends narrow payloads

  // One slot mux shared by single-slot reads (DECODE) and streaming.
  assign sel_idx = (state_q == ST_DECODE) ? {1'b0, rx_lo[6:0]} : cur_q;

  always_comb begin
    slot_sel = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (sel_idx == 8'(i)) slot_sel = slots[i*DATA_W +: DATA_W];
    end
  end

  // UPDATE_ALL is a range covering every slot.
  always_comb begin
    if (cmd == CMD_UPDATE_ALL) begin
      rng_start = 8'd0;
      rng_count = SLOT_COUNT_B;
    end else begin
      rng_start = rx_lo[7:0];
      rng_count = rx_lo[15:8];
    end
    rng_end = {1'b0, rng_start} + {1'b0, rng_count};
  end

  always_comb begin
    state_d   = state_q;
    pop_d     = 1'b0;
    push_d    = 1'b0;
    rst_dev_d = 1'b0;
    var_d     = '0;
    vl_d      = '0;
    tx_cmd_d  = tx_cmd_q;
    tx_data_d = tx_data_q;
    cur_d     = cur_q;
    end_d     = end_q;
    cnt_d     = cnt_q;
    act_idx_d = act_idx_q;
    param_we  = 1'b0;
    lost_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (lost_q) begin
          tx_cmd_d  = RSP_ERROR;
          tx_data_d = DATA_W'(ERR_LOST_DATA);
          lost_clr  = 1'b1;
          state_d   = ST_TX_WAIT;
        end else if (!bus.rx_empty) begin
          pop_d   = 1'b1;
          state_d = ST_POP;
        end
      end

      ST_POP: state_d = ST_DECODE;

      ST_DECODE: begin
        state_d = ST_TX_WAIT;
        if (cmd[7]) begin
          act_idx_d = cmd[5:0];
          if (cmd[6] && ({2'b00, cmd[5:0]} < VAR_COUNT_B)) begin
            param_we = 1'b1;
            state_d  = ST_VAR_PULSE;
          end else if (!cmd[6] && ({2'b00, cmd[5:0]} < VL_COUNT_B)) begin
            for (int i = 0; i < VARLESS_ACTION_COUNT; i++) begin
              vl_d[i] = (8'(i) == {2'b00, cmd[5:0]});
            end
            state_d = ST_IDLE;
          end else begin
            tx_cmd_d  = RSP_INVALID_ACTION;
            tx_data_d = DATA_W'(cmd[5:0]);
          end
        end else begin
          case (cmd)
            CMD_PING: begin
              tx_cmd_d  = RSP_PONG;
              tx_data_d = '0;
            end
            CMD_UPDATE_SLOT: begin
              if ({1'b0, rx_lo[6:0]} < SLOT_COUNT_B) begin
                tx_cmd_d  = RSP_SLOT_BASE | {1'b0, rx_lo[6:0]};
                tx_data_d = slot_sel;
              end else begin
                tx_cmd_d  = RSP_INVALID_SLOT;
                tx_data_d = DATA_W'(rx_lo[6:0]);
              end
            end
            CMD_UPDATE_ALL, CMD_UPDATE_RANGE: begin
              if (rng_end > 9'(SLOT_COUNT)) begin
                tx_cmd_d  = RSP_INVALID_SLOT;
                tx_data_d = DATA_W'(rng_start);
              end else if (rng_count == 8'd0) begin
                tx_cmd_d  = RSP_DONE;
                tx_data_d = '0;
              end else begin
                cur_d   = rng_start;
                end_d   = rng_end[7:0];
                cnt_d   = rng_count;
                state_d = ST_STREAM;
              end
            end
            CMD_ASK_SLOT_COUNT: begin
              tx_cmd_d  = RSP_SLOT_COUNT;
              tx_data_d = DATA_W'(SLOT_COUNT_B);
            end
            CMD_ASK_ACTION_COUNT: begin
              tx_cmd_d  = RSP_ACTION_COUNT;
              tx_data_d = DATA_W'({VL_COUNT_B, VAR_COUNT_B});
            end
            CMD_RESET: begin
              rst_dev_d = 1'b1;
              state_d   = ST_IDLE;
            end
            default: begin
              tx_cmd_d  = RSP_UNKNOWN;
              tx_data_d = DATA_W'(cmd);
            end
          endcase
        end
      end

      ST_TX_WAIT: begin
        if (!bus.tx_full) begin
          push_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_STREAM: begin
        if (cur_q == end_q) begin
          tx_cmd_d  = RSP_DONE;
          tx_data_d = DATA_W'(cnt_q);
          state_d   = ST_TX_WAIT;
        end else if (!bus.tx_full) begin
          tx_cmd_d  = RSP_SLOT_BASE | {1'b0, cur_q[6:0]};
          tx_data_d = slot_sel;
          push_d    = 1'b1;
          cur_d     = cur_q + 8'd1;
          state_d   = ST_STREAM_GAP;
        end
      end

      ST_STREAM_GAP: state_d = ST_STREAM;

      ST_VAR_PULSE: begin
        for (int i = 0; i < VAR_ACTION_COUNT; i++) begin
          var_d[i] = (8'(i) == {2'b00, act_idx_q});
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pop_q     <= 1'b0;
      push_q    <= 1'b0;
      rst_dev_q <= 1'b0;
      tx_cmd_q  <= '0;
      tx_data_q <= '0;
      var_q     <= '0;
      vl_q      <= '0;
      param_q   <= '0;
      cur_q     <= '0;
      end_q     <= '0;
      cnt_q     <= '0;
      act_idx_q <= '0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pop_q     <= pop_d;
      push_q    <= push_d;
      rst_dev_q <= rst_dev_d;
      tx_cmd_q  <= tx_cmd_d;
      tx_data_q <= tx_data_d;
      var_q     <= var_d;
      vl_q      <= vl_d;
      cur_q     <= cur_d;
      end_q     <= end_d;
      cnt_q     <= cnt_d;
      act_idx_q <= act_idx_d;
      // a new loss in the same cycle as the report keeps the flag set
      lost_q    <= bus.rx_lost_data | (lost_q & ~lost_clr);
      if (param_we) begin
        for (int i = 0; i < VAR_ACTION_COUNT; i++) begin
          if (8'(i) == {2'b00, act_idx_d}) param_q[i*DATA_W +: DATA_W] <= bus.rx_data;
        end
      end
    end
  end

  assign bus.rx_pop_packet  = pop_q;
  assign bus.tx_push_packet = push_q;
  assign bus.tx_command     = tx_cmd_q;
  assign bus.tx_data        = tx_data_q;
  assign rst_device           = rst_dev_q;
  assign var_actions          = var_q;
  assign varless_actions      = vl_q;
  assign var_action_parameter = param_q;

endmodule

// File: tb/tb_hedios_controller_v2.sv
module tb_hedios_controller_v2;
  localparam int DW  = 32;
  localparam int SC  = 4;
  localparam int VC  = 2;
  localparam int VLC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_device;
  logic [SC*DW-1:0]  slots;
  logic [VC-1:0]     var_actions;
  logic [VC*DW-1:0]  var_action_parameter;
  logic [VLC-1:0]    varless_actions;

  hedios_controller_v2_if #(.DATA_W(DW)) bus();

  hedios_controller_v2 #(
    .DATA_W(DW), .SLOT_COUNT(SC), .VAR_ACTION_COUNT(VC), .VARLESS_ACTION_COUNT(VLC)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus                  (bus),
    .rst_device           (rst_device),
    .slots                (slots),
    .var_actions          (var_actions),
    .var_action_parameter (var_action_parameter),
    .varless_actions      (varless_actions)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] cmd; logic [DW-1:0] data; int cyc; } pkt_t;
  typedef struct { int kind; int idx; logic [DW-1:0] data; } act_t;  // kind 0 var, 1 varless, 2 reset

  pkt_t rx_mem[$];
  pkt_t exp_tx[$];
  act_t exp_act[$];
  logic [DW-1:0] slot_mem [SC];

  int n_vec = 0;
  int n_err = 0;
  int n_in = 0;
  int n_out = 0;
  int cyc = 0;
  logic full_at_edge = 1'b0;
  logic prev_push = 1'b0;
  logic [VC*DW-1:0] prev_param = '0;
  logic rand_full_en = 1'b0;
  logic force_full = 1'b0;

  always_comb begin
    for (int i = 0; i < SC; i++) slots[i*DW +: DW] = slot_mem[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // rx FIFO: head packet registered on the edge that sees the pop
  assign bus.rx_empty = (n_in == n_out);
  always @(posedge clk) begin
    if (bus.rx_pop_packet && n_out < n_in) begin
      bus.rx_command <= rx_mem[n_out].cmd;
      bus.rx_data    <= rx_mem[n_out].data;
      n_out          <= n_out + 1;
    end
    cyc          <= cyc + 1;
    full_at_edge <= bus.tx_full;
  end

  always @(negedge clk) bus.tx_full = rand_full_en ? ($urandom_range(0, 9) < 3) : force_full;

  // reference model: expected responses of one client packet
  task automatic push_tx(input logic [7:0] c, input logic [DW-1:0] d);
    pkt_t p;
    p.cmd = c; p.data = d; p.cyc = -1;
    exp_tx.push_back(p);
  endtask

  task automatic push_act(input int kind, input int idx, input logic [DW-1:0] d);
    act_t a;
    a.kind = kind; a.idx = idx; a.data = d;
    exp_act.push_back(a);
  endtask

  task automatic model_range(input int start, input int count);
    if (start + count > SC) push_tx(8'h09, DW'(start));
    else begin
      for (int i = start; i < start + count; i++) push_tx(8'(128 + i), slot_mem[i]);
      push_tx(8'h02, DW'(count));
    end
  endtask

  task automatic model(input logic [7:0] c, input logic [DW-1:0] d);
    int idx;
    idx = int'(c) % 64;
    if (c >= 8'hC0) begin
      if (idx < VC) push_act(0, idx, d); else push_tx(8'h0A, DW'(idx));
    end else if (c >= 8'h80) begin
      if (idx < VLC) push_act(1, idx, '0); else push_tx(8'h0A, DW'(idx));
    end else if (c == 8'h01) push_tx(8'h03, '0);
    else if (c == 8'h02) begin
      idx = int'(d) % 128;
      if (idx < SC) push_tx(8'(128 + idx), slot_mem[idx]); else push_tx(8'h09, DW'(idx));
    end
    else if (c == 8'h03) model_range(0, SC);
    else if (c == 8'h04) push_tx(8'h05, DW'(SC));
    else if (c == 8'h05) push_tx(8'h06, DW'(VLC * 256 + VC));
    else if (c == 8'h06) model_range(int'(d) % 256, (int'(d) / 256) % 256);
    else if (c == 8'h55) push_act(2, 0, '0);
    else push_tx(8'h0B, DW'(c));
  endtask

  task automatic send(input logic [7:0] c, input logic [DW-1:0] d);
    pkt_t p;
    p.cmd = c; p.data = d; p.cyc = -1;
    rx_mem.push_back(p);
    n_in++;
    model(c, d);
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_act.size() == 0 && n_out == n_in) break;
    end
    if (k == 3000) check("drain_timeout", 64'(exp_tx.size() + exp_act.size()), 64'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop"}, 64'(bus.rx_pop_packet), 64'd0);
    check({tag, "_push"}, 64'(bus.tx_push_packet), 64'd0);
    check({tag, "_tx_cmd"}, 64'(bus.tx_command), 64'd0);
    check({tag, "_tx_data"}, 64'(bus.tx_data), 64'd0);
    check({tag, "_rst_device"}, 64'(rst_device), 64'd0);
    check({tag, "_var"}, 64'(var_actions), 64'd0);
    check({tag, "_varless"}, 64'(varless_actions), 64'd0);
    check({tag, "_param"}, 64'(var_action_parameter), 64'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    pkt_t e;
    act_t a;
    if (rst_n) begin
      if (bus.tx_push_packet) begin
        check("push_gap", 64'(prev_push), 64'd0);
        check("push_while_full", 64'(full_at_edge), 64'd0);
        if (exp_tx.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_push: got cmd %0h data %0h, required no push", bus.tx_command, bus.tx_data);
        end else begin
          e = exp_tx.pop_front();
          check("tx_command", 64'(bus.tx_command), 64'(e.cmd));
          check("tx_data", 64'(bus.tx_data), 64'(e.data));
          if (e.cyc >= 0) check("ping_latency", 64'(cyc), 64'(e.cyc));
        end
      end
      if (var_actions != '0 || varless_actions != '0 || rst_device) begin
        if (exp_act.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_pulse: got var %0h varless %0h rst %0b, required none",
                   var_actions, varless_actions, rst_device);
        end else begin
          a = exp_act.pop_front();
          if (a.kind == 0) begin
            check("var_pulse", 64'(var_actions), 64'(1) << a.idx);
            check("var_param_before", 64'(prev_param[a.idx*DW +: DW]), 64'(a.data));
            check("var_param_now", 64'(var_action_parameter[a.idx*DW +: DW]), 64'(a.data));
          end else if (a.kind == 1) begin
            check("varless_pulse", 64'(varless_actions), 64'(1) << a.idx);
            check("varless_var_quiet", 64'(var_actions), 64'd0);
          end else begin
            check("rst_device", 64'(rst_device), 64'd1);
            check("rst_device_quiet", 64'({var_actions, varless_actions}), 64'd0);
          end
        end
      end
    end
    prev_push  = bus.tx_push_packet;
    prev_param = var_action_parameter;
  end

  initial begin
    logic [7:0] c;
    logic [DW-1:0] d;
    logic [7:0] unk [5];
    unk[0] = 8'h00; unk[1] = 8'h07; unk[2] = 8'h40; unk[3] = 8'h7F; unk[4] = 8'h56;

    rst_n = 1'b0;
    bus.rx_lost_data = 1'b0;
    for (int i = 0; i < SC; i++) slot_mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // PING latency
    send(8'h01, '0);
    exp_tx[exp_tx.size() - 1].cyc = cyc + 4;
    wait_drain();

    // ranged streaming
    slot_mem[0] = 32'hAAAA_0000; slot_mem[1] = 32'hBBBB_1111;
    slot_mem[2] = 32'hCCCC_2222; slot_mem[3] = 32'hDDDD_3333;
    send(8'h06, 32'h0000_0201);
    wait_drain();
    send(8'h06, 32'h0000_0203);
    send(8'h06, 32'h0000_0004);
    wait_drain();

    // backpressure across a full stream
    force_full = 1'b1;
    send(8'h03, '0);
    repeat (10) @(negedge clk);
    force_full = 1'b0;
    wait_drain();

    // actions
    send(8'hC1, 32'hDEADBEEF);
    send(8'hC5, 32'h1234_5678);
    send(8'h81, '0);
    send(8'h83, '0);
    wait_drain();
    check("param1_held", 64'(var_action_parameter[DW +: DW]), 64'h0000_0000_DEAD_BEEF);

    // lost data while a packet is pending
    force_full = 1'b1;
    send(8'h01, '0);
    repeat (8) @(negedge clk);
    bus.rx_lost_data = 1'b1; @(negedge clk);
    bus.rx_lost_data = 1'b0; @(negedge clk);
    bus.rx_lost_data = 1'b1; @(negedge clk);
    bus.rx_lost_data = 1'b0;
    push_tx(8'h08, DW'(1));
    send(8'h05, '0);
    repeat (3) @(negedge clk);
    force_full = 1'b0;
    wait_drain();

    // randomized traffic with random backpressure
    rand_full_en = 1'b1;
    for (int it = 0; it < 150; it++) begin
      if (it % 30 == 0) begin
        wait_drain();
        for (int i = 0; i < SC; i++) slot_mem[i] = $urandom;
      end
      d = $urandom;
      case ($urandom_range(0, 9))
        0: c = 8'h01;
        1: begin c = 8'h02; d = DW'($urandom_range(0, 7)); end
        2: c = 8'h03;
        3: c = 8'h04;
        4: c = 8'h05;
        5: begin c = 8'h06; d = DW'($urandom_range(0, 5) * 256 + $urandom_range(0, 5)); end
        6: c = 8'(8'hC0 + $urandom_range(0, 3));
        7: c = 8'(8'h80 + $urandom_range(0, 3));
        8: c = 8'h55;
        default: c = unk[$urandom_range(0, 4)];
      endcase
      send(c, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (it % 5 == 4) wait_drain();
    end
    wait_drain();
    rand_full_en = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of a stream
    send(8'hC0, 32'h5A5A_A5A5);
    wait_drain();
    send(8'h03, '0);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_tx.delete();
    exp_act.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("residual_expect", 64'(exp_tx.size() + exp_act.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
